wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writers.
  - The in-order pipeline write-back stage.
  - A long-latency unit (mul/div, late load) that completes out of band.
- Pipeline writes have priority.
- The long-latency result is parked in a one-entry holding buffer until it gets a free port cycle.
- If the buffer is starved too long, the arbiter stalls the pipeline for one cycle to force a drain.
- Sits between the write-back stage / long-latency unit and the register file.

---
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 tb/tb_wb_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority,
// long-latency results wait in a one-entry buffer with starvation relief.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int REGNUM_W     = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_we,
  input  logic [REGNUM_W-1:0] pipe_dst,
  input  logic [XLEN-1:0]     pipe_value,
  input  logic                lu_valid,
  output logic                lu_ready,
  input  logic [REGNUM_W-1:0] lu_dst,
  input  logic [XLEN-1:0]     lu_value,
  output logic                pipe_stall,
  output logic                rf_we,
  output logic [REGNUM_W-1:0] rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                pend_valid,
  output logic [REGNUM_W-1:0] pend_dst
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  localparam logic [3:0] LIM_M1 = 4'(STARVE_LIMIT - 1);

  logic [1:0]          r_state;
  logic [3:0]          r_cnt;
  logic [REGNUM_W-1:0] r_pdst;
  logic [XLEN-1:0]     r_pval;
  logic                r_we;
  logic [REGNUM_W-1:0] r_waddr;
  logic [XLEN-1:0]     r_wdata;

  logic                w_preq;
  logic                w_gbuf;
  logic                w_kill;
  logic                w_acc;
  logic [3:0]          w_cnt_inc;

  assign pend_valid = (r_state != S_EMPTY);
  assign pend_dst   = r_pdst;
  assign lu_ready   = rst & ~pend_valid;
  assign pipe_stall = rst & (r_state == S_FORCE);

  assign w_preq    = pipe_we & (pipe_dst != '0) & ~pipe_stall;
  assign w_gbuf    = ~w_preq & pend_valid;
  assign w_kill    = w_preq & pend_valid & (pipe_dst == r_pdst);
  assign w_acc     = lu_valid & lu_ready & (lu_dst != '0);
  assign w_cnt_inc = r_cnt + 4'd1;

  // Buffer occupancy FSM and starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          r_cnt <= '0;
          if (w_acc) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_gbuf || w_kill) begin
            r_state <= S_EMPTY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= LIM_M1) r_state <= S_FORCE;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Load the holding buffer on an accepted nonzero-destination result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pdst <= '0;
      r_pval <= '0;
    end else if (w_acc) begin
      r_pdst <= lu_dst;
      r_pval <= lu_value;
    end
  end

  // Register the granted write toward the register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_preq | w_gbuf;
      if (w_preq) begin
        r_waddr <= pipe_dst;
        r_wdata <= pipe_value;
      end else if (w_gbuf) begin
        r_waddr <= r_pdst;
        r_wdata <= r_pval;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with an ordered
// scoreboard of expected register-file writes.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_dst = '0;
  logic [31:0] pipe_value = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_dst = '0;
  logic [31:0] lu_value = '0;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pend_valid;
  logic [4:0]  pend_dst;

  int n_chk = 0;
  int n_err = 0;
  logic [36:0] q[$];

  wb_port_arbiter #(.XLEN(32), .REGNUM_W(5), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_dst(pipe_dst), .pipe_value(pipe_value),
    .lu_valid(lu_valid), .lu_ready(lu_ready),
    .lu_dst(lu_dst), .lu_value(lu_value),
    .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_dst(pend_dst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    q.push_back({a, d});
  endtask

  // Every observed register-file write must match the next expected one
  always @(negedge clk) begin
    if (rst && rf_we) begin
      if (q.size() == 0) begin
        chk("rf_unexp", {27'd0, rf_waddr, rf_wdata}, 64'd0);
      end else begin
        logic [36:0] e;
        e = q.pop_front();
        chk("rf_waddr", 64'(rf_waddr), 64'(e[36:32]));
        chk("rf_wdata", 64'(rf_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic lu_send(input logic [4:0] d, input logic [31:0] v);
    lu_valid = 1'b1;
    lu_dst   = d;
    lu_value = v;
    #1 chk("lu_ready_acc", 64'(lu_ready), 64'd1);
    step();
    lu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    pipe_we  = 1'b0;
    lu_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
    chk("q_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_pend", 64'(pend_valid), 64'd0);
    chk("rst_pdst", 64'(pend_dst), 64'd0);
    chk("rst_lu_rdy", 64'(lu_ready), 64'd0);
    chk("rst_stall", 64'(pipe_stall), 64'd0);
    rst = 1'b1;
    #1 chk("rel_lu_rdy", 64'(lu_ready), 64'd1);
    step();

    // free-port drain
    push(5'd7, 32'hDEAD_BEEF);
    lu_send(5'd7, 32'hDEAD_BEEF);
    chk("drain_pend", 64'(pend_valid), 64'd1);
    chk("drain_pdst", 64'(pend_dst), 64'd7);
    chk("drain_rdy0", 64'(lu_ready), 64'd0);
    step();
    chk("drain_we", 64'(rf_we), 64'd1);
    chk("drain_pend0", 64'(pend_valid), 64'd0);
    chk("drain_rdy1", 64'(lu_ready), 64'd1);
    idle(2);

    // pipe priority over buffer
    push(5'd5, 32'h11);
    push(5'd5, 32'h11);
    push(5'd3, 32'h33);
    lu_send(5'd3, 32'h33);
    pipe_we = 1'b1; pipe_dst = 5'd5; pipe_value = 32'h11;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) pipe_we = 1'b0;
      #1 chk("prio_stall", 64'(pipe_stall), 64'd0);
      step();
    end
    idle(2);

    // starvation forces a one-cycle stall
    push(5'd1, 32'h111);
    push(5'd1, 32'h111);
    push(5'd1, 32'h111);
    push(5'd9, 32'h99);
    push(5'd1, 32'h111);
    lu_send(5'd9, 32'h99);
    pipe_we = 1'b1; pipe_dst = 5'd1; pipe_value = 32'h111;
    for (int i = 0; i < 5; i++) begin
      #1 chk("starve_stall", 64'(pipe_stall), 64'(i == 3));
      step();
    end
    idle(2);

    // WAW kill drops stale buffered entry
    push(5'd4, 32'hBBBB);
    lu_send(5'd4, 32'hAAAA);
    pipe_we = 1'b1; pipe_dst = 5'd4; pipe_value = 32'hBBBB;
    step();
    pipe_we = 1'b0;
    chk("waw_pend0", 64'(pend_valid), 64'd0);
    idle(3);

    // x0 pipe writes are ignored, buffer gets the port
    push(5'd6, 32'h66);
    lu_send(5'd6, 32'h66);
    pipe_we = 1'b1; pipe_dst = 5'd0; pipe_value = 32'h123;
    step();
    chk("x0_pend0", 64'(pend_valid), 64'd0);
    step();
    chk("x0_no_we", 64'(rf_we), 64'd0);
    pipe_we = 1'b0;
    idle(1);

    // lu entry to x0 is accepted and discarded
    lu_send(5'd0, 32'h77);
    chk("lu_x0_pend", 64'(pend_valid), 64'd0);
    chk("lu_x0_rdy", 64'(lu_ready), 64'd1);
    step();
    chk("lu_x0_we", 64'(rf_we), 64'd0);
    idle(1);

    // reset while a result is buffered discards it
    lu_send(5'd8, 32'h88);
    chk("mid_pend1", 64'(pend_valid), 64'd1);
    rst = 1'b0;
    #1 chk("mid_pend0", 64'(pend_valid), 64'd0);
    chk("mid_rdy0", 64'(lu_ready), 64'd0);
    step();
    rst = 1'b1;
    #1 chk("mid_rdy1", 64'(lu_ready), 64'd1);
    chk("mid_we", 64'(rf_we), 64'd0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
